// File: rtl/ysyx_20020207_axi_pkg.sv
// rtl/ysyx_20020207_axi_pkg.sv - shared AXI burst/response encodings and ROM slave FSM states
package ysyx_20020207_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND
    } state_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/ysyx_20020207_axi_burst_addr.sv
// rtl/ysyx_20020207_axi_burst_addr.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
//
// Ports:
//   addr      in  ADDR_W  current beat byte address
//   size      in  3       log2 bytes per beat
//   len       in  8       beats minus 1
//   burst     in  2       burst type encoding
//   next_addr out ADDR_W  byte address of the following beat
module ysyx_20020207_axi_burst_addr
    import ysyx_20020207_axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;

    always_comb begin
        step = ONE << size;
        incr = addr + step;
        // Wrap container is (len+1)*step bytes; a power of two for legal WRAP lengths.
        mask = ((ADDR_W'(len) + ONE) << size) - ONE;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr;
            BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
            default:     next_addr = addr;
        endcase
    end

endmodule

// File: rtl/ysyx_20020207_axi_rom_slave.sv
// rtl/ysyx_20020207_axi_rom_slave.sv - AXI4 read-only memory responder with backdoor load port
//
// Ports:
//   clock, reset            clock and asynchronous active-low reset
//   io_slave_ar*            AR channel (one outstanding burst)
//   io_slave_r*             R channel, rdata is the full aligned word
//   ld_wen/ld_addr/ld_wdata backdoor word write for loading the image
module ysyx_20020207_axi_rom_slave
    import ysyx_20020207_axi_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter int                DEPTH_W = 12,
    parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
    parameter int                LAT     = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_slave_arvalid,
    output logic               io_slave_arready,
    input  logic [ADDR_W-1:0]  io_slave_araddr,
    input  logic [7:0]         io_slave_arlen,
    input  logic [2:0]         io_slave_arsize,
    input  logic [1:0]         io_slave_arburst,
    output logic               io_slave_rvalid,
    input  logic               io_slave_rready,
    output logic [31:0]        io_slave_rdata,
    output logic [1:0]         io_slave_rresp,
    output logic               io_slave_rlast,
    input  logic               ld_wen,
    input  logic [DEPTH_W-1:0] ld_addr,
    input  logic [31:0]        ld_wdata
);

    localparam logic [ADDR_W-1:0] WORDS    = ADDR_W'(1) << DEPTH_W;
    localparam logic [3:0]        LAT_INIT = 4'(LAT);

    logic [31:0] mem [0:(1<<DEPTH_W)-1];

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [7:0]        beat_cnt;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              slverr;
    logic [3:0]        lat_cnt;

    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] word_off;
    logic [DEPTH_W-1:0] fetch_idx;
    logic              in_range;
    logic              ar_slverr;
    logic [1:0]        beat_resp;
    logic [31:0]       beat_data;

    ysyx_20020207_axi_burst_addr #(.ADDR_W(ADDR_W)) u_burst_addr (
        .addr      (addr),
        .size      (size),
        .len       (len),
        .burst     (burst),
        .next_addr (next_addr)
    );

    // The word for the upcoming beat is looked up here and captured into rdata
    // on the edge that presents the beat: beat 0 uses the captured start address,
    // later beats use the sequenced next address.
    assign fetch_addr = (state == ST_SEND) ? next_addr : addr;
    // Subtraction wraps for addresses below BASE, so one unsigned compare covers both ends.
    assign word_off   = (fetch_addr - BASE) >> 2;
    assign in_range   = word_off < WORDS;
    assign fetch_idx  = word_off[DEPTH_W-1:0];

    assign ar_slverr = (io_slave_arsize > 3'd2)
                    || (io_slave_arburst == BURST_RSVD)
                    || ((io_slave_arburst == BURST_WRAP) && !wrap_len_ok(io_slave_arlen));

    always_comb begin
        beat_resp = RESP_OKAY;
        beat_data = 32'd0;
        if (slverr) begin
            beat_resp = RESP_SLVERR;
        end else if (!in_range) begin
            beat_resp = RESP_DECERR;
        end else begin
            beat_data = mem[fetch_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (ld_wen) begin
            mem[ld_addr] <= ld_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= ST_IDLE;
            addr             <= '0;
            len              <= 8'd0;
            beat_cnt         <= 8'd0;
            size             <= 3'd0;
            burst            <= 2'd0;
            slverr           <= 1'b0;
            lat_cnt          <= 4'd0;
            io_slave_arready <= 1'b0;
            io_slave_rvalid  <= 1'b0;
            io_slave_rlast   <= 1'b0;
            io_slave_rresp   <= 2'd0;
            io_slave_rdata   <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (io_slave_arvalid && io_slave_arready) begin
                        state            <= ST_WAIT;
                        addr             <= io_slave_araddr;
                        len              <= io_slave_arlen;
                        size             <= io_slave_arsize;
                        burst            <= io_slave_arburst;
                        slverr           <= ar_slverr;
                        lat_cnt          <= LAT_INIT;
                        beat_cnt         <= 8'd0;
                        io_slave_arready <= 1'b0;
                    end else begin
                        io_slave_arready <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        state           <= ST_SEND;
                        io_slave_rvalid <= 1'b1;
                        io_slave_rlast  <= (len == 8'd0);
                        io_slave_rresp  <= beat_resp;
                        io_slave_rdata  <= beat_data;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                ST_SEND: begin
                    if (io_slave_rvalid && io_slave_rready) begin
                        if (io_slave_rlast) begin
                            state            <= ST_IDLE;
                            io_slave_rvalid  <= 1'b0;
                            io_slave_rlast   <= 1'b0;
                            io_slave_arready <= 1'b1;
                        end else begin
                            addr           <= next_addr;
                            beat_cnt       <= beat_cnt + 8'd1;
                            io_slave_rlast <= ((beat_cnt + 8'd1) == len);
                            io_slave_rresp <= beat_resp;
                            io_slave_rdata <= beat_data;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_20020207_axi_rom_slave.sv
// tb/tb_ysyx_20020207_axi_rom_slave.sv - directed self-checking bench for the AXI ROM slave
module tb_ysyx_20020207_axi_rom_slave;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] araddr = 32'd0;
    logic [7:0]  arlen = 8'd0;
    logic [2:0]  arsize = 3'd0;
    logic [1:0]  arburst = 2'd0;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        ld_wen = 1'b0;
    logic [11:0] ld_addr = 12'd0;
    logic [31:0] ld_wdata = 32'd0;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_w [4];

    always #5 clock = ~clock;

    ysyx_20020207_axi_rom_slave dut (
        .clock            (clock),
        .reset            (reset),
        .io_slave_arvalid (arvalid),
        .io_slave_arready (arready),
        .io_slave_araddr  (araddr),
        .io_slave_arlen   (arlen),
        .io_slave_arsize  (arsize),
        .io_slave_arburst (arburst),
        .io_slave_rvalid  (rvalid),
        .io_slave_rready  (rready),
        .io_slave_rdata   (rdata),
        .io_slave_rresp   (rresp),
        .io_slave_rlast   (rlast),
        .ld_wen           (ld_wen),
        .ld_addr          (ld_addr),
        .ld_wdata         (ld_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [11:0] idx, input logic [31:0] d);
        ld_wen   = 1'b1;
        ld_addr  = idx;
        ld_wdata = d;
        @(negedge clock);
        ld_wen   = 1'b0;
    endtask

    // Presents an AR at a negedge and returns at the negedge after the handshake edge.
    task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b);
        int n;
        arvalid = 1'b1;
        araddr  = a;
        arlen   = l;
        arsize  = s;
        arburst = b;
        n = 0;
        while (arready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("ar_accept", {31'd0, arready}, 32'd1);
        @(negedge clock);
        arvalid = 1'b0;
    endtask

    task automatic wait_rvalid(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (rvalid !== 1'b1 && n < 40) begin
            chk({tag, "_arready_busy"}, {31'd0, arready}, 32'd0);
            @(negedge clock);
            n++;
        end
        chk({tag, "_latency"}, n, exp_cycles);
    endtask

    task automatic recv(input string tag, input logic [31:0] d, input logic [1:0] r, input logic l);
        rready = 1'b1;
        chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        chk({tag, "_rdata"}, rdata, d);
        chk({tag, "_rresp"}, {30'd0, rresp}, {30'd0, r});
        chk({tag, "_rlast"}, {31'd0, rlast}, {31'd0, l});
        chk({tag, "_arready"}, {31'd0, arready}, 32'd0);
        @(negedge clock);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
        chk({tag, "_arready"}, {31'd0, arready}, 32'd1);
    endtask

    initial begin
        int beat;
        int cyc;
        exp_w[0] = 32'd11;
        exp_w[1] = 32'd22;
        exp_w[2] = 32'd33;
        exp_w[3] = 32'd44;

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rlast", {31'd0, rlast}, 32'd0);
        chk("rst_rresp", {30'd0, rresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rel_arready", {31'd0, arready}, 32'd1);

        load(12'd0, 32'd11);
        load(12'd1, 32'd22);
        load(12'd2, 32'd33);
        load(12'd3, 32'd44);

        // INCR 4 beats
        send_ar(32'h8000_0000, 8'd3, 3'd2, 2'b01);
        wait_rvalid("t1", 3);
        recv("t1_b0", 32'd11, 2'b00, 1'b0);
        recv("t1_b1", 32'd22, 2'b00, 1'b0);
        recv("t1_b2", 32'd33, 2'b00, 1'b0);
        recv("t1_b3", 32'd44, 2'b00, 1'b1);
        idle_chk("t1_end");

        // WRAP 4 beats starting at word 2
        send_ar(32'h8000_0008, 8'd3, 3'd2, 2'b10);
        wait_rvalid("t2", 3);
        recv("t2_b0", 32'd33, 2'b00, 1'b0);
        recv("t2_b1", 32'd44, 2'b00, 1'b0);
        recv("t2_b2", 32'd11, 2'b00, 1'b0);
        recv("t2_b3", 32'd22, 2'b00, 1'b1);
        idle_chk("t2_end");

        // INCR with rready pattern 1,0,0,1,...
        rready = 1'b0;
        send_ar(32'h8000_0000, 8'd3, 3'd2, 2'b01);
        wait_rvalid("t3", 3);
        beat = 0;
        cyc = 0;
        while (beat < 4 && cyc < 40) begin
            chk("t3_rvalid", {31'd0, rvalid}, 32'd1);
            chk("t3_rdata", rdata, exp_w[beat]);
            chk("t3_rlast", {31'd0, rlast}, (beat == 3) ? 32'd1 : 32'd0);
            rready = ((cyc % 3) == 0);
            @(negedge clock);
            if (rready) beat++;
            cyc++;
        end
        chk("t3_handshakes", beat, 4);
        idle_chk("t3_end");
        rready = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("t3_no_extra", {31'd0, rvalid}, 32'd0);
        end

        // DECERR then OKAY across BASE
        send_ar(32'h7FFF_FFFC, 8'd1, 3'd2, 2'b01);
        wait_rvalid("t4a", 3);
        recv("t4a_b0", 32'd0, 2'b11, 1'b0);
        recv("t4a_b1", 32'd11, 2'b00, 1'b1);
        idle_chk("t4a_end");

        // Reserved burst type -> SLVERR every beat
        send_ar(32'h8000_0000, 8'd1, 3'd2, 2'b11);
        wait_rvalid("t4b", 3);
        recv("t4b_b0", 32'd0, 2'b10, 1'b0);
        recv("t4b_b1", 32'd0, 2'b10, 1'b1);
        idle_chk("t4b_end");

        // FIXED 3 beats with a second AR held pending
        send_ar(32'h8000_0004, 8'd2, 3'd2, 2'b00);
        arvalid = 1'b1;
        araddr  = 32'h8000_000C;
        arlen   = 8'd0;
        arsize  = 3'd2;
        arburst = 2'b01;
        wait_rvalid("t5", 3);
        recv("t5_b0", 32'd22, 2'b00, 1'b0);
        recv("t5_b1", 32'd22, 2'b00, 1'b0);
        recv("t5_b2", 32'd22, 2'b00, 1'b1);
        chk("t5_arready_ret", {31'd0, arready}, 32'd1);
        @(negedge clock);
        arvalid = 1'b0;
        chk("t5_second_taken", {31'd0, arready}, 32'd0);
        wait_rvalid("t5b", 3);
        recv("t5b_b0", 32'd44, 2'b00, 1'b1);
        idle_chk("t5_end");

        // Reset mid-burst
        send_ar(32'h8000_0000, 8'd3, 3'd2, 2'b01);
        wait_rvalid("t6", 3);
        recv("t6_b0", 32'd11, 2'b00, 1'b0);
        chk("t6_b1_valid", {31'd0, rvalid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("t6_rst_arready", {31'd0, arready}, 32'd0);
        chk("t6_rst_rlast", {31'd0, rlast}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("t6_rel_arready", {31'd0, arready}, 32'd1);
        chk("t6_rel_rvalid", {31'd0, rvalid}, 32'd0);
        send_ar(32'h8000_000C, 8'd0, 3'd2, 2'b01);
        wait_rvalid("t6b", 3);
        recv("t6b_b0", 32'd44, 2'b00, 1'b1);
        idle_chk("t6_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_20020207_axi_rom_slave.md
Name: ysyx_20020207_axi_rom_slave

Overview:
AXI4 read-only responder modelling the instruction memory behind the IFU/ICACHE read master. It accepts one AR request at a time, waits a programmable first-beat latency, then returns arlen+1 beats on R with FIXED/INCR/WRAP address sequencing and rlast. A word-wide backdoor write port loads the program image. It is used as the simulation memory for the IFU burst path and in unit benches.

Parameters:
ADDR_W, 32, AXI address width
DEPTH_W, 12, log2 of memory depth in 32-bit words (4096 words = 16 KiB)
BASE, 32'h8000_0000, byte address of word 0; must be aligned to 4<<DEPTH_W
LAT, 2, idle cycles between AR handshake and first rvalid (0..15)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
io_slave_arvalid  in  1  AR valid
io_slave_arready  out  1  AR ready
io_slave_araddr  in  ADDR_W  burst start byte address
io_slave_arlen  in  8  beats minus 1
io_slave_arsize  in  3  log2 bytes per beat
io_slave_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
io_slave_rvalid  out  1  R valid
io_slave_rready  in  1  R ready
io_slave_rdata  out  32  read data, full aligned word
io_slave_rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
io_slave_rlast  out  1  last beat of burst
ld_wen  in  1  backdoor write enable
ld_addr  in  DEPTH_W  backdoor word index
ld_wdata  in  32  backdoor write data

Behaviour:
- Reset (reset=0, async): state IDLE; arready=0, rvalid=0, rlast=0, rresp=0, rdata=0; beat and latency counters 0. Memory contents are not reset. Reset mid-burst aborts the burst; no further beats are returned.
- arready is registered: 1 in IDLE from the first clock edge after reset release; 0 in all other states.
- FSM IDLE -> WAIT on arvalid&&arready. Capture addr, len, size, burst; load lat_cnt=LAT; arready<=0.
- WAIT: lat_cnt decrements each cycle; at 0 -> SEND with rvalid<=1 and beat 0 presented. With LAT=0, rvalid rises on the cycle after the AR handshake.
- SEND: rdata/rresp/rlast are held stable while rvalid&&!rready. On rvalid&&rready: if rlast -> IDLE (rvalid<=0, arready<=1, so the next AR is accepted one cycle after the last beat); otherwise advance the address and present the next beat on the next cycle (back-to-back, one beat per cycle while rready=1).
- rlast=1 exactly when beat_cnt==len.
- Address sequencing, with step=1<<size:
  - FIXED: address unchanged.
  - INCR: addr+=step.
  - WRAP: container=(len+1)*step bytes; addr=(addr & ~(container-1)) | ((addr+step) & (container-1)).
- Data: rdata=mem[(addr-BASE)>>2] (whole word, lanes not shifted; master selects bytes). The memory read is synchronous; the word is fetched one cycle before the beat is presented.
- Errors are per beat; the full burst is still returned with rlast.
  - DECERR with rdata=0: addr<BASE or addr>=BASE+(4<<DEPTH_W).
  - SLVERR with rdata=0 on all beats: arsize>2, arburst=11, or WRAP with len not in {1,3,7,15}.
  - Unaligned start (addr not a multiple of step) is allowed; data is returned from the containing word.
  - INCR crossing the top of the array produces DECERR for the out-of-range beats only.
- Backdoor: on ld_wen, mem[ld_addr]<=ld_wdata at the clock edge. A backdoor write to the word being read in the same cycle returns the old data.
- arvalid arriving during WAIT/SEND is ignored (not accepted) until the return to IDLE.

Decomposition:
- Shared package ysyx_20020207_axi_pkg: burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/SLVERR/DECERR), FSM state typedef.
- One sub-module: ysyx_20020207_axi_burst_addr. It is combinational and produces next_addr from addr/size/len/burst. It is shared with a future AXI write slave.

Test Plan:
- Reset, load mem[0..3]=11,22,33,44; AR addr=0x8000_0000, len=3, size=2, INCR, LAT=2, rready=1 -> first rvalid 3 cycles after AR handshake; 4 beats 11,22,33,44; rlast on beat 3; rresp=00.
- WRAP, addr=0x8000_0008, len=3, size=2 -> beats from words 2,3,0,1 (33,44,11,22); rlast on the 4th beat.
- Same INCR burst with rready toggled 1,0,0,1,... -> rdata/rlast stable during stalls; exactly 4 handshakes; arready returns to 1 the cycle after the last handshake.
- AR addr=0x7FFF_FFFC, len=1, INCR -> beat0 DECERR rdata=0; beat1 (0x8000_0000) OKAY 11. Separately arburst=11 -> SLVERR with rlast on the final beat.
- FIXED, len=2, addr=0x8000_0004 -> 22,22,22. A second arvalid held high during the burst is accepted only after rlast.
- reset=0 asserted mid-burst at beat 1 -> rvalid=0, arready=0 immediately; after release arready=1 next edge, and a new burst returns correct data.
